// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with a start/busy/done handshake.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    scratch;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    scratch_shifted;
    logic [CW-1:0]    cnt;
    logic             last_shift;

`ifdef BIN2BCD_SIGNED_EN
    logic sign;
    logic sign_in;

    // The magnitude of -2**(WIDTH-1) still fits in WIDTH unsigned bits.
    always_comb begin
        sign_in = bin[WIDTH-1];
        mag     = sign_in ? (~bin + WIDTH'(1)) : bin;
    end
`else
    assign mag = bin;
    assign neg = 1'b0;
`endif

    // Add3 is per digit; a corrected digit never exceeds 4 bits, so no inter-digit carry exists.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        scratch_shifted = {adj[BW-2:0], shreg[WIDTH-1]};
    end

    assign last_shift = (cnt == CW'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign    <= 1'b0;
            neg     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= mag;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
`ifdef BIN2BCD_SIGNED_EN
                        sign    <= sign_in;
`endif
                    end
                end
                SHIFT: begin
                    scratch <= scratch_shifted;
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                    // Result registers load on entry to FINISH so they are valid with done.
                    if (last_shift) begin
                        bcd <= scratch_shifted;
`ifdef BIN2BCD_SIGNED_EN
                        neg <= sign;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
